// File: rtl/ifetch_line_responder.sv
// Instruction-fetch responder: one-line buffer answering hits combinationally,
// refilling the line from backing memory with a single burst on a miss.
module ifetch_line_responder #(
    parameter  int LINE_WORDS = 4,
    localparam int OFF_W      = $clog2(LINE_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction_address,
    output logic [31:0] instruction_read_data,
    output logic        instruction_valid,
    input  logic        flush,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int          TAG_W = 32 - OFF_W - 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               buf_valid;
    logic [TAG_W-1:0]   buf_tag;
    logic [TAG_W-1:0]   req_tag;
    logic [OFF_W-1:0]   beat_cnt;
    logic               flush_pend;
    logic [31:0]        line [LINE_WORDS];

    logic [TAG_W-1:0]   tag;
    logic [OFF_W-1:0]   offset;
    logic               tag_match;
    logic               miss;
    logic               last_beat;
    logic               hit;
    logic               unused_addr_bits;

    assign tag              = instruction_address[31:OFF_W+2];
    assign offset           = instruction_address[OFF_W+1:2];
    assign unused_addr_bits = ^instruction_address[1:0];
    assign tag_match        = buf_valid && (tag == buf_tag);
    assign miss             = !flush && !tag_match;
    assign last_beat        = (beat_cnt == OFF_W'(LINE_WORDS - 1));

    // State register; reset drops any in-flight burst and returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the combinational hit path and request valid.
    always_comb begin
        state_next            = state;
        mem_req_valid         = 1'b0;
        hit                   = 1'b0;
        instruction_valid     = 1'b0;
        instruction_read_data = NOP;
        case (state)
            IDLE: begin
                hit = tag_match && !flush;
                if (miss) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (mem_resp_valid && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        instruction_valid = hit;
        if (rst) begin
            instruction_read_data = 32'h0;
        end else if (hit) begin
            instruction_read_data = line[offset];
        end
    end

    // Buffer bookkeeping: tag/valid, the latched request and the fill counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid    <= 1'b0;
            buf_tag      <= '0;
            req_tag      <= '0;
            beat_cnt     <= '0;
            flush_pend   <= 1'b0;
            mem_req_addr <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        buf_valid <= 1'b0;
                    end else if (miss) begin
                        buf_valid    <= 1'b0;
                        req_tag      <= tag;
                        mem_req_addr <= {tag, {(OFF_W + 2){1'b0}}};
                        flush_pend   <= 1'b0;
                    end
                end
                REQ: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        beat_cnt <= '0;
                    end
                end
                FILL: begin
                    if (flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_resp_valid) begin
                        beat_cnt <= beat_cnt + OFF_W'(1);
                        if (last_beat) begin
                            buf_tag    <= req_tag;
                            buf_valid  <= !flush_pend && !flush;
                            flush_pend <= 1'b0;
                        end
                    end
                end
                default: begin
                    buf_valid <= 1'b0;
                end
            endcase
        end
    end

    // Line storage; beats land in order only while a fill is in progress.
    always_ff @(posedge clk) begin
        if (state == FILL && mem_resp_valid) begin
            line[beat_cnt] <= mem_resp_data;
        end
    end

endmodule

// File: tb/tb_ifetch_line_responder.sv
// Directed testbench for ifetch_line_responder with a hand-driven memory slave.
module tb_ifetch_line_responder;

    logic        clk;
    logic        rst;
    logic [31:0] instruction_address;
    logic [31:0] instruction_read_data;
    logic        instruction_valid;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    int errors = 0;
    int checks = 0;
    int hs_count = 0;
    int hs_start = 0;

    ifetch_line_responder #(.LINE_WORDS(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .instruction_address   (instruction_address),
        .instruction_read_data (instruction_read_data),
        .instruction_valid     (instruction_valid),
        .flush                 (flush),
        .mem_req_valid         (mem_req_valid),
        .mem_req_addr          (mem_req_addr),
        .mem_req_ready         (mem_req_ready),
        .mem_resp_valid        (mem_resp_valid),
        .mem_resp_data         (mem_resp_data)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted burst requests.
    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            hs_count <= hs_count + 1;
        end
    end

    function automatic logic [31:0] beatWord(input logic [31:0] base, input int i);
        logic [31:0] w;
        if (base == 32'h0) begin
            case (i)
                0:       w = 32'h0000_0013;
                1:       w = 32'h0010_0093;
                2:       w = 32'h0020_0113;
                default: w = 32'h0030_0193;
            endcase
        end else begin
            w = 32'hC0DE_0000 | base | 32'(i);
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a_addr, input logic a_flush,
                                 input logic a_ready, input logic a_rv,
                                 input logic [31:0] a_rd);
        instruction_address = a_addr;
        flush               = a_flush;
        mem_req_ready       = a_ready;
        mem_resp_valid      = a_rv;
        mem_resp_data       = a_rd;
        #1;
    endtask

    // Drives four in-order beats starting in the first FILL cycle.
    task automatic fillLine(input logic [31:0] base, input logic [31:0] a_addr,
                            input int flush_beat);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(a_addr, (i == flush_beat), 1'b1, 1'b1, beatWord(base, i));
            checkOutput("fill_valid", {31'b0, instruction_valid}, 32'd0);
            checkOutput("fill_req_valid", {31'b0, mem_req_valid}, 32'd0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        instruction_address = 32'h0;
        flush = 1'b0;
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = 32'h0;
        #2;
        checkOutput("rst_valid", {31'b0, instruction_valid}, 32'd0);
        checkOutput("rst_data", instruction_read_data, 32'h0);
        checkOutput("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("rst_req_addr", mem_req_addr, 32'h0);
        tick();
        tick();

        // Cold miss at 0x0
        rst = 1'b0;
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("cold_miss_valid", {31'b0, instruction_valid}, 32'd0);
        checkOutput("cold_idle_req", {31'b0, mem_req_valid}, 32'd0);
        hs_start = hs_count;
        tick();
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("cold_req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("cold_req_addr", mem_req_addr, 32'h0);
        tick();
        fillLine(32'h0, 32'h0, -1);
        applyStimulus(32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("cold_hit0_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("cold_hit0_data", instruction_read_data, 32'h0000_0013);
        for (int i = 1; i < 4; i++) begin
            tick();
            applyStimulus(32'(i * 4), 1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("cold_hit_valid", {31'b0, instruction_valid}, 32'd1);
            checkOutput("cold_hit_data", instruction_read_data, beatWord(32'h0, i));
        end
        checkOutput("cold_handshakes", 32'(hs_count - hs_start), 32'd1);

        // Line crossing 0xC -> 0x10
        tick();
        applyStimulus(32'h10, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("cross_miss_valid", {31'b0, instruction_valid}, 32'd0);
        tick();
        applyStimulus(32'h10, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("cross_req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("cross_req_addr", mem_req_addr, 32'h10);
        tick();
        fillLine(32'h10, 32'h10, -1);
        applyStimulus(32'h10, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("cross_hit_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("cross_hit_data", instruction_read_data, beatWord(32'h10, 0));

        // Back-pressure on the request channel
        tick();
        applyStimulus(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bp_miss_valid", {31'b0, instruction_valid}, 32'd0);
        hs_start = hs_count;
        for (int i = 0; i < 5; i++) begin
            tick();
            applyStimulus(32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("bp_wait_req_valid", {31'b0, mem_req_valid}, 32'd1);
            checkOutput("bp_wait_req_addr", mem_req_addr, 32'h40);
        end
        tick();
        applyStimulus(32'h40, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("bp_ready_req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("bp_ready_req_addr", mem_req_addr, 32'h40);
        tick();
        fillLine(32'h40, 32'h40, -1);
        checkOutput("bp_handshakes", 32'(hs_count - hs_start), 32'd1);
        applyStimulus(32'h4C, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("bp_hit_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("bp_hit_data", instruction_read_data, beatWord(32'h40, 3));

        // Jump from 0x20 to 0x100 during the second beat
        tick();
        applyStimulus(32'h20, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("jump_miss_valid", {31'b0, instruction_valid}, 32'd0);
        tick();
        applyStimulus(32'h20, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("jump_req_addr", mem_req_addr, 32'h20);
        tick();
        applyStimulus(32'h20, 1'b0, 1'b1, 1'b1, beatWord(32'h20, 0));
        checkOutput("jump_beat0_valid", {31'b0, instruction_valid}, 32'd0);
        tick();
        for (int i = 1; i < 4; i++) begin
            applyStimulus(32'h100, 1'b0, 1'b1, 1'b1, beatWord(32'h20, i));
            checkOutput("jump_beat_valid", {31'b0, instruction_valid}, 32'd0);
            tick();
        end
        applyStimulus(32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("jump_idle_miss_valid", {31'b0, instruction_valid}, 32'd0);
        checkOutput("jump_idle_req_valid", {31'b0, mem_req_valid}, 32'd0);
        tick();
        applyStimulus(32'h100, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("jump_new_req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("jump_new_req_addr", mem_req_addr, 32'h100);
        tick();
        fillLine(32'h100, 32'h100, -1);
        applyStimulus(32'h108, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("jump_hit_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("jump_hit_data", instruction_read_data, beatWord(32'h100, 2));

        // Flush on a hit cycle, then during FILL, then on the last beat
        tick();
        applyStimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_pre_hit", {31'b0, instruction_valid}, 32'd1);
        tick();
        applyStimulus(32'h104, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_cycle_valid", {31'b0, instruction_valid}, 32'd0);
        checkOutput("flush_cycle_data", instruction_read_data, 32'h0000_0013);
        tick();
        applyStimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_after_valid", {31'b0, instruction_valid}, 32'd0);
        tick();
        applyStimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_rereq_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("flush_rereq_addr", mem_req_addr, 32'h100);
        tick();
        fillLine(32'h100, 32'h104, 1);
        applyStimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_fill_invalid", {31'b0, instruction_valid}, 32'd0);
        tick();
        applyStimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_second_req", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("flush_second_addr", mem_req_addr, 32'h100);
        tick();
        fillLine(32'h100, 32'h104, 3);
        applyStimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_last_invalid", {31'b0, instruction_valid}, 32'd0);
        tick();
        applyStimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_third_req", {31'b0, mem_req_valid}, 32'd1);
        tick();
        fillLine(32'h100, 32'h104, -1);
        applyStimulus(32'h104, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("flush_final_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("flush_final_data", instruction_read_data, beatWord(32'h100, 1));

        // Reset after two beats of a fill, then a stray beat in IDLE
        tick();
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rmf_miss_valid", {31'b0, instruction_valid}, 32'd0);
        tick();
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rmf_req_addr", mem_req_addr, 32'h200);
        tick();
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b1, beatWord(32'h200, 0));
        tick();
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b1, beatWord(32'h200, 1));
        tick();
        rst = 1'b1;
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rmf_rst_valid", {31'b0, instruction_valid}, 32'd0);
        checkOutput("rmf_rst_data", instruction_read_data, 32'h0);
        checkOutput("rmf_rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        checkOutput("rmf_rst_req_addr", mem_req_addr, 32'h0);
        tick();
        rst = 1'b0;
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        checkOutput("rmf_stray_valid", {31'b0, instruction_valid}, 32'd0);
        checkOutput("rmf_stray_req_valid", {31'b0, mem_req_valid}, 32'd0);
        tick();
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rmf_new_req_valid", {31'b0, mem_req_valid}, 32'd1);
        checkOutput("rmf_new_req_addr", mem_req_addr, 32'h200);
        tick();
        fillLine(32'h200, 32'h200, -1);
        applyStimulus(32'h200, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rmf_hit0_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("rmf_hit0_data", instruction_read_data, beatWord(32'h200, 0));
        tick();
        applyStimulus(32'h20C, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rmf_hit3_valid", {31'b0, instruction_valid}, 32'd1);
        checkOutput("rmf_hit3_data", instruction_read_data, beatWord(32'h200, 3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
